// File: rtl/pipe_stage_skid_pkg.sv
// ============================================================================
// Module      : pipe_pkg
// Description : Shared state encoding and defaults for the skid pipeline stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

  localparam int PIPE_OCC_W      = 2;
  localparam int PIPE_DATA_W_DEF = 64;
  localparam int PIPE_CTRL_W_DEF = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b10
  } pipe_state_t;

  // Entry count held in each state; the unused encoding reads as empty.
  function automatic logic [PIPE_OCC_W-1:0] occ_of(input pipe_state_t s);
    case (s)
      ONE:     occ_of = 2'd1;
      TWO:     occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_stage_skid_if.sv
// ============================================================================
// Module      : pipe_stage_skid_if
// Description : Upstream/downstream valid-ready bundle plus flush for the stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipe_stage_skid_if #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8
);
  import pipe_pkg::*;

  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [CTRL_W-1:0]     in_ctrl;
  logic [DATA_W-1:0]     in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [CTRL_W-1:0]     out_ctrl;
  logic [DATA_W-1:0]     out_data;
  logic [PIPE_OCC_W-1:0] occupancy;

  modport slave (
    input  flush, in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data, occupancy
  );

  modport master (
    output flush, in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data, occupancy
  );

endinterface

`default_nettype wire

// File: rtl/pipe_stage_skid_perf_cnt.sv
// ============================================================================
// Module      : pipe_perf_cnt
// Description : 32-bit saturating event counter with enable, async reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_perf_cnt (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic [31:0] cnt
);

  logic [31:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= 32'd0;
    end else if (en && (r_cnt != 32'hFFFF_FFFF)) begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  assign cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_skid.sv
// ============================================================================
// Module      : pipe_stage_skid
// Description : Generic pipeline stage register with valid/ready handshake and
//               a 2-entry skid buffer. Define PIPE_STAGE_PERF_EN to add the
//               stall_cnt / bubble_cnt performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                DATA_W   = PIPE_DATA_W_DEF,
  parameter int                CTRL_W   = PIPE_CTRL_W_DEF,
  parameter logic [CTRL_W-1:0] CTRL_BUB = {CTRL_W{1'b0}}
) (
  input  logic        clk,
  input  logic        reset,
`ifdef PIPE_STAGE_PERF_EN
  output logic [31:0] stall_cnt,
  output logic [31:0] bubble_cnt,
`endif
  pipe_stage_skid_if.slave bus
);

  pipe_state_t       r_state;
  pipe_state_t       w_state_nxt;
  logic              r_live;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic [DATA_W-1:0] r_skid_data;

  logic w_in_ready;
  logic w_out_valid;
  logic w_push;
  logic w_pop;
  logic w_ld_main_in;
  logic w_ld_main_skid;
  logic w_ld_skid;

  // in_ready comes only from flops so it never depends on out_ready.
  assign w_in_ready  = r_live & (r_state != TWO);
  assign w_out_valid = (r_state != EMPTY);
  assign w_push      = bus.in_valid & w_in_ready;
  assign w_pop       = w_out_valid & bus.out_ready;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_ctrl  = w_out_valid ? r_main_ctrl : CTRL_BUB;
  assign bus.out_data  = r_main_data;
  assign bus.occupancy = occ_of(r_state);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= EMPTY;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_live  <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    if (bus.flush) begin
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_push) begin
            w_state_nxt  = ONE;
            w_ld_main_in = 1'b1;
          end
        end
        ONE: begin
          if (w_push && w_pop) begin
            w_ld_main_in = 1'b1;
          end else if (w_push) begin
            w_state_nxt = TWO;
            w_ld_skid   = 1'b1;
          end else if (w_pop) begin
            w_state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (w_pop) begin
            w_state_nxt    = ONE;
            w_ld_main_skid = 1'b1;
          end
        end
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main_ctrl <= CTRL_BUB;
      r_main_data <= '0;
      r_skid_ctrl <= CTRL_BUB;
      r_skid_data <= '0;
    end else if (bus.flush) begin
      r_main_ctrl <= CTRL_BUB;
      r_main_data <= '0;
      r_skid_ctrl <= CTRL_BUB;
      r_skid_data <= '0;
    end else begin
      if (w_ld_main_in) begin
        r_main_ctrl <= bus.in_ctrl;
        r_main_data <= bus.in_data;
      end else if (w_ld_main_skid) begin
        r_main_ctrl <= r_skid_ctrl;
        r_main_data <= r_skid_data;
      end
      if (w_ld_skid) begin
        r_skid_ctrl <= bus.in_ctrl;
        r_skid_data <= bus.in_data;
      end
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  pipe_perf_cnt u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (w_out_valid & ~bus.out_ready),
    .cnt   (stall_cnt)
  );

  pipe_perf_cnt u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (~w_out_valid & ~bus.flush),
    .cnt   (bubble_cnt)
  );
`endif

endmodule

`default_nettype wire
